// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: request/result bundle for the bit-serial subtractor.
//   master : drives start, a, b, bin; observes busy, done, diff, bout (and ovf)
//   slave  : the subtractor side; observes the request, drives the result
//   start  : request, sampled only while the subtractor is idle
//   a, b   : minuend / subtrahend, WIDTH bits, sampled with start
//   bin    : borrow-in, sampled with start
//   busy   : high while bits are being resolved
//   done   : one-cycle pulse, diff/bout (and ovf) valid
//   diff   : a - b - bin modulo 2^WIDTH
//   bout   : final borrow, 1 iff a < b + bin (unsigned)
//   ovf    : signed overflow flag, present only with SERIAL_SUB_OVF_EN defined
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

`ifdef SERIAL_SUB_OVF_EN
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
`else
  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
`endif

endinterface : serial_subtractor_if

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor, diff = a - b - bin.
//   Operands are latched on an accepted start, then one bit per clock is
//   resolved LSB first through a 1-bit full-subtractor cell and a borrow
//   flip-flop. Result bits enter diff from the MSB side so that after WIDTH
//   shifts the LSB sits at diff[0].
//
// Ports
//   clk  : rising-edge clock
//   rst  : asynchronous reset, active-high
//   bus  : serial_subtractor_if.slave (start, a, b, bin -> busy, done, diff,
//          bout, and ovf when enabled)
//
// Parameters
//   WIDTH : operand/result width, legal range 2..32
//
// Configuration macro
//   SERIAL_SUB_OVF_EN : adds the registered two's-complement overflow flag
//                       bus.ovf = (a[msb] ^ b[msb]) & (a[msb] ^ diff[msb]).
//
// Timing (start accepted on edge 0)
//   edges 1..WIDTH-1 : SHIFT, one bit per edge, busy=1
//   edge  WIDTH      : DONE cycle resolves the last bit; busy=0, done=1
//   edge  WIDTH+1    : done drops; a new start can be accepted here
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             brw;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             busy_q;
  logic             done_q;

  // full-subtractor cell outputs for the current LSB pair
  logic             d_c;
  logic             brw_nxt_c;

`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb;
  logic             b_msb;
  logic             ovf_q;
`endif

  // 1-bit full subtractor: difference and borrow for a_sh[0] - b_sh[0] - brw
  always_comb begin
    d_c       = 1'b0;
    brw_nxt_c = 1'b0;
    d_c       = a_sh[0] ^ b_sh[0] ^ brw;
    brw_nxt_c = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & brw);
  end

  // control FSM and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      ovf_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            brw    <= bus.bin;
            cnt    <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            busy_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
            // operand sign bits are shifted away, so keep them for the flag
            a_msb  <= bus.a[WIDTH-1];
            b_msb  <= bus.b[WIDTH-1];
            ovf_q  <= 1'b0;
`endif
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          brw    <= brw_nxt_c;
          diff_q <= {d_c, diff_q[WIDTH-1:1]};
          cnt    <= cnt + CNT_W'(1);
          // counter becomes WIDTH-1: one bit left, resolved in DONE
          if (cnt == CNT_W'(WIDTH - 2)) begin
            state <= DONE;
          end
        end

        DONE: begin
          // final bit; d_c is the result MSB
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          brw    <= brw_nxt_c;
          diff_q <= {d_c, diff_q[WIDTH-1:1]};
          bout_q <= brw_nxt_c;
          busy_q <= 1'b0;
          done_q <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_q  <= (a_msb ^ b_msb) & (a_msb ^ d_c);
`endif
          state  <= IDLE;
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // result drive
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed and randomized checks of serial_subtractor
// (WIDTH=8) against an integer-arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // single comparison point
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference: plain integer subtraction; ovf follows the sign-bit formula
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int r;
    r  = int'(a) - int'(b) - int'(bin);
    d  = W'(r);
    bo = (r < 0);
    ov = (a[W-1] ^ b[W-1]) & (a[W-1] ^ d[W-1]);
  endtask

  // one full operation: accept, latency count, result, done drop and hold
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input string tag, input bit full);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           lat;
    model(a, b, bin, ed, eb, eo);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    bus.bin   = ~bin;
    if (full) check({tag, ".busy"}, 64'(bus.busy), 64'd1);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 4 * W);
    if (full) check({tag, ".lat"}, 64'(lat), 64'(W));
    check({tag, ".diff"}, 64'(bus.diff), 64'(ed));
    check({tag, ".bout"}, 64'(bus.bout), 64'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, ".ovf"}, 64'(bus.ovf), 64'(eo));
`endif
    if (full) begin
      check({tag, ".busy_end"}, 64'(bus.busy), 64'd0);
      @(posedge clk);
      #1;
      check({tag, ".done_drop"}, 64'(bus.done), 64'd0);
      check({tag, ".diff_hold"}, 64'(bus.diff), 64'(ed));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rbin;
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           n;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.diff", 64'(bus.diff), 64'd0);
    check("rst.bout", 64'(bus.bout), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst.ovf", 64'(bus.ovf), 64'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // directed cases, including the boundary operands
    run_op(8'h05, 8'h03, 1'b0, "t1", 1'b1);
    check("t1.diff_lit", 64'(bus.diff), 64'h02);
    run_op(8'h00, 8'h01, 1'b0, "t2a", 1'b1);
    check("t2a.diff_lit", 64'(bus.diff), 64'hFF);
    run_op(8'h3C, 8'h3C, 1'b1, "t2b", 1'b1);
    check("t2b.bout_lit", 64'(bus.bout), 64'd1);
    run_op(8'h80, 8'h01, 1'b0, "t3a", 1'b1);
    check("t3a.diff_lit", 64'(bus.diff), 64'h7F);
    run_op(8'h10, 8'h20, 1'b0, "t3b", 1'b1);
    run_op(8'h00, 8'h00, 1'b0, "zero", 1'b1);
    run_op(8'hFF, 8'hFF, 1'b1, "ones_bin", 1'b1);

    // start held high through SHIFT/DONE is ignored until idle again
    @(negedge clk);
    bus.a     = 8'h05;
    bus.b     = 8'h03;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a = 8'hFF;
    bus.b = 8'h00;
    for (int k = 1; k < int'(W); k++) begin
      @(posedge clk);
      #1;
      check("t4.no_early_done", 64'(bus.done), 64'd0);
    end
    @(posedge clk);
    #1;
    check("t4.done", 64'(bus.done), 64'd1);
    check("t4.diff", 64'(bus.diff), 64'h02);
    check("t4.busy_done", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
    check("t4.reaccept_busy", 64'(bus.busy), 64'd1);
    check("t4.reaccept_diff", 64'(bus.diff), 64'h00);
    bus.start = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.done && n < 4 * W);
    check("t4.lat2", 64'(n), 64'(W));
    check("t4.diff2", 64'(bus.diff), 64'hFF);
    check("t4.bout2", 64'(bus.bout), 64'd0);

    // asynchronous reset mid-operation
    @(negedge clk);
    bus.a     = 8'h05;
    bus.b     = 8'h03;
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("t5.busy", 64'(bus.busy), 64'd0);
    check("t5.done", 64'(bus.done), 64'd0);
    check("t5.diff", 64'(bus.diff), 64'd0);
    check("t5.bout", 64'(bus.bout), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (W + 2) begin
      @(posedge clk);
      #1;
      if (bus.done) n++;
    end
    check("t5.no_done", 64'(n), 64'd0);
    run_op(8'h09, 8'h04, 1'b0, "t5b", 1'b1);
    check("t5b.diff_lit", 64'(bus.diff), 64'h05);

    // randomized operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      run_op(ra, rb, rbin, "rnd", (i % 50) == 0);
    end

    // a fully random run leaves the last result held while idle
    model(ra, rb, rbin, ed, eb, eo);
    repeat (3) @(posedge clk);
    #1;
    check("hold.diff", 64'(bus.diff), 64'(ed));
    check("hold.bout", 64'(bus.bout), 64'(eb));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
